mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the pipeline's fetch port (i_*) and data port (d_*).

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_lat_counter.sv | 27 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// State and port-select encodings plus counter sizing.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_WAIT = 2'd1,
        ST_D_WAIT = 2'd2,
        ST_ACK    = 2'd3
    } arb_state_e;

    typedef enum logic {
        SEL_D = 1'b0,
        SEL_I = 1'b1
    } port_sel_e;

    function automatic int lat_cnt_w(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU-side fetch/data ports and the memory-side bus of the arbiter.
// slave = arbiter view, master = core + memory model view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              stall_f;
    logic              stall_m;
    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_rdata, i_ack, d_rdata, d_ack,
        output m_en, m_we, m_addr, m_wdata,
        output stall_f, stall_m, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack,
        input  m_en, m_we, m_addr, m_wdata,
        input  stall_f, stall_m, busy
    );
endinterface

// File: rtl/mem_lat_counter.sv
// Loadable down-counter sequencing the fixed memory read latency.
// zero_next flags the last wait edge (count of one).
module mem_lat_counter #(
    parameter int MEM_LAT = 2,
    parameter int W       = $clog2(MEM_LAT + 1)
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero_next
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= value;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero_next = (r_cnt == W'(1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one single-port memory.
// Round-robin under contention, fixed read latency, one-cycle acks.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic clock,
    input  logic rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = lat_cnt_w(MEM_LAT);

    arb_state_e        r_state;
    logic              r_rr;
    logic              r_i_ack;
    logic              r_d_ack;
    logic              r_m_en;
    logic              r_m_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_arb;
    logic              w_grant;
    logic              w_wait;
    logic              w_zero_next;
    port_sel_e         w_win;

    // The port acked this cycle is masked so its held req is not re-granted
    assign w_i_req = bus.i_req & ~r_i_ack;
    assign w_d_req = bus.d_req & ~r_d_ack;
    assign w_arb   = (r_state == ST_IDLE) | (r_state == ST_ACK);
    assign w_grant = w_arb & (w_i_req | w_d_req);
    assign w_wait  = (r_state == ST_I_WAIT) | (r_state == ST_D_WAIT);

    // r_rr=1 after a data grant hands the next tie to fetch
    always_comb begin
        w_win = SEL_D;
        if (w_i_req && (!w_d_req || r_rr)) begin
            w_win = SEL_I;
        end
    end

    mem_lat_counter #(
        .MEM_LAT (MEM_LAT),
        .W       (CW)
    ) u_lat (
        .clock     (clock),
        .rst_n     (rst_n),
        .load      (w_grant),
        .value     (CW'(MEM_LAT)),
        .dec       (w_wait),
        .zero_next (w_zero_next)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rr      <= 1'b0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_m_en    <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_m_en  <= 1'b0;
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_ACK: begin
                    if (w_grant) begin
                        r_m_en <= 1'b1;
                        r_rr   <= (w_win == SEL_D);
                        if (w_win == SEL_D) begin
                            r_m_addr  <= bus.d_addr;
                            r_m_we    <= bus.d_we;
                            r_m_wdata <= bus.d_wdata;
                            r_state   <= ST_D_WAIT;
                        end else begin
                            r_m_addr <= bus.i_addr;
                            r_m_we   <= 1'b0;
                            r_state  <= ST_I_WAIT;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_I_WAIT: begin
                    if (w_zero_next) begin
                        r_i_rdata <= bus.m_rdata;
                        r_i_ack   <= 1'b1;
                        r_state   <= ST_ACK;
                    end
                end
                ST_D_WAIT: begin
                    if (r_m_we) begin
                        r_d_ack <= 1'b1;
                        r_state <= ST_ACK;
                    end else if (w_zero_next) begin
                        r_d_rdata <= bus.m_rdata;
                        r_d_ack   <= 1'b1;
                        r_state   <= ST_ACK;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.i_rdata = r_i_rdata;
    assign bus.i_ack   = r_i_ack;
    assign bus.d_rdata = r_d_rdata;
    assign bus.d_ack   = r_d_ack;
    assign bus.m_en    = r_m_en;
    assign bus.m_we    = r_m_we;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
    assign bus.stall_f = bus.i_req & ~r_i_ack;
    assign bus.stall_m = bus.d_req & ~r_d_ack;
    assign bus.busy    = (r_state != ST_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timeline reference model,
// directed scenarios, random traffic, and a MEM_LAT=1 instance.
module tb_mem_port_arbiter;
    localparam int LAT0 = 2;

    logic clock = 1'b0;
    logic rst_n0 = 1'b0;
    logic rst_n1 = 1'b0;
    always #5 clock = ~clock;

    mem_port_arbiter_if b0 ();
    mem_port_arbiter_if b1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT0)) u0 (
        .clock (clock),
        .rst_n (rst_n0),
        .bus   (b0)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
        .clock (clock),
        .rst_n (rst_n1),
        .bus   (b1)
    );

    // Memory model: read data follows the held address, writes on m_en&m_we
    logic [31:0] mem0 [16];
    assign b0.m_rdata = mem0[b0.m_addr[5:2]];
    always @(posedge clock) begin
        if (rst_n0 && b0.m_en && b0.m_we) mem0[b0.m_addr[5:2]] = b0.m_wdata;
    end
    assign b1.m_rdata = 32'hdd;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Reference model: each grant schedules its ack edge on a timeline
    logic [31:0] ref_mem [16];
    int n = 0;
    int next_dec, ack_edge, busy_to;
    bit pend, pend_d, pend_we, mask_i, mask_d, fetch_turn;
    logic [31:0] pend_data;
    logic [31:0] e_m_addr, e_m_wdata, e_i_rdata, e_d_rdata;
    bit e_m_en, e_m_we, e_i_ack, e_d_ack, e_busy;

    task automatic model_reset();
        next_dec = n + 1;
        pend = 0; mask_i = 0; mask_d = 0; fetch_turn = 0;
        busy_to = -1;
        e_m_en = 0; e_m_we = 0; e_i_ack = 0; e_d_ack = 0; e_busy = 0;
        e_m_addr = 0; e_m_wdata = 0; e_i_rdata = 0; e_d_rdata = 0;
    endtask

    task automatic model_edge();
        bit ir, dr, win_d;
        int lat;
        n++;
        e_m_en = 0; e_i_ack = 0; e_d_ack = 0;
        if (pend && n == ack_edge) begin
            pend = 0;
            if (pend_d) begin
                e_d_ack = 1;
                if (!pend_we) e_d_rdata = pend_data;
            end else begin
                e_i_ack = 1;
                e_i_rdata = pend_data;
            end
        end
        if (n >= next_dec) begin
            ir = b0.i_req && !mask_i;
            dr = b0.d_req && !mask_d;
            mask_i = 0; mask_d = 0;
            if (ir || dr) begin
                win_d = dr && (!ir || !fetch_turn);
                fetch_turn = win_d;
                e_m_en = 1;
                if (win_d) begin
                    e_m_addr = b0.d_addr;
                    e_m_we = b0.d_we;
                    if (b0.d_we) begin
                        e_m_wdata = b0.d_wdata;
                        ref_mem[b0.d_addr[5:2]] = b0.d_wdata;
                    end
                    pend_data = ref_mem[b0.d_addr[5:2]];
                    lat = b0.d_we ? 1 : LAT0;
                end else begin
                    e_m_addr = b0.i_addr;
                    e_m_we = 0;
                    pend_data = ref_mem[b0.i_addr[5:2]];
                    lat = LAT0;
                end
                pend = 1; pend_d = win_d; pend_we = win_d && b0.d_we;
                ack_edge = n + lat;
                next_dec = ack_edge + 1;
                busy_to = ack_edge;
                mask_i = !win_d; mask_d = win_d;
            end else begin
                next_dec = n + 1;
            end
        end
        e_busy = (n <= busy_to);
    endtask

    task automatic check_outs();
        chk("m_en", b0.m_en, e_m_en);
        chk("m_we", b0.m_we, e_m_we);
        chk("m_addr", b0.m_addr, e_m_addr);
        if (e_m_en && e_m_we) chk("m_wdata", b0.m_wdata, e_m_wdata);
        chk("i_ack", b0.i_ack, e_i_ack);
        chk("d_ack", b0.d_ack, e_d_ack);
        chk("i_rdata", b0.i_rdata, e_i_rdata);
        chk("d_rdata", b0.d_rdata, e_d_rdata);
        chk("busy", b0.busy, e_busy);
        chk("stall_f", b0.stall_f, b0.i_req & ~e_i_ack);
        chk("stall_m", b0.stall_m, b0.d_req & ~e_d_ack);
    endtask

    task automatic cyc();
        @(posedge clock);
        if (rst_n0) model_edge();
        @(negedge clock);
        if (rst_n0) check_outs();
    endtask

    task automatic apply_reset();
        rst_n0 = 0;
        b0.i_req = 0; b0.d_req = 0; b0.d_we = 0;
        model_reset();
        repeat (2) cyc();
        rst_n0 = 1;
    endtask

    task automatic set_mem(input int idx, input logic [31:0] v);
        mem0[idx] = v;
        ref_mem[idx] = v;
    endtask

    task automatic wait_ack(input bit dport, output int k);
        k = -1;
        for (int c = 1; c <= 30; c++) begin
            cyc();
            if ((dport && b0.d_ack) || (!dport && b0.i_ack)) begin
                k = c;
                break;
            end
        end
    endtask

    int k;
    int got_acks;
    bit ord [4];
    logic [31:0] want4 [3];

    initial begin
        for (int i = 0; i < 16; i++) set_mem(i, $urandom());
        b0.i_req = 0; b0.i_addr = 0; b0.d_req = 0; b0.d_we = 0;
        b0.d_addr = 0; b0.d_wdata = 0;
        b1.i_req = 0; b1.i_addr = 0; b1.d_req = 0; b1.d_we = 0;
        b1.d_addr = 0; b1.d_wdata = 0;
        @(negedge clock);
        apply_reset();
        chk("rst_busy", b0.busy, 0);
        chk("rst_maddr", b0.m_addr, 0);

        // Lone load
        set_mem(4, 32'h5);
        b0.d_req = 1; b0.d_we = 0; b0.d_addr = 32'h10;
        wait_ack(1, k);
        chk("t1_lat", k, 3);
        chk("t1_rdata", b0.d_rdata, 32'h5);
        chk("t1_maddr", b0.m_addr, 32'h10);
        b0.d_req = 0;
        cyc();
        chk("t1_stall", b0.stall_m, 0);

        // Lone store, d_rdata keeps the earlier load value
        b0.d_req = 1; b0.d_we = 1; b0.d_addr = 32'h104; b0.d_wdata = 32'h1;
        wait_ack(1, k);
        chk("t2_lat", k, 2);
        chk("t2_rdata", b0.d_rdata, 32'h5);
        chk("t2_mwe", b0.m_we, 1);
        chk("t2_mwdata", b0.m_wdata, 32'h1);
        b0.d_req = 0; b0.d_we = 0;
        cyc();
        chk("t2_mem", mem0[1], 32'h1);

        // Contention: strict alternation starting with data
        apply_reset();
        b0.i_addr = 32'h200; b0.d_addr = 32'h300;
        b0.i_req = 1; b0.d_req = 1;
        got_acks = 0;
        for (int c = 0; c < 60 && got_acks < 4; c++) begin
            cyc();
            chk("t3_ovl", b0.i_ack & b0.d_ack, 0);
            if (b0.i_ack || b0.d_ack) begin
                ord[got_acks] = b0.d_ack;
                got_acks++;
                if (b0.d_ack) b0.d_addr += 4;
                else b0.i_addr += 4;
            end
        end
        chk("t3_cnt", got_acks, 4);
        for (int j = 0; j < 4; j++) chk("t3_order", ord[j], (j % 2) == 0);
        b0.i_req = 0; b0.d_req = 0;
        repeat (2) cyc();

        // Fetch stream
        apply_reset();
        want4[0] = 32'h8C010000;
        want4[1] = 32'h8C020000;
        want4[2] = 32'h8C030000;
        for (int j = 0; j < 3; j++) set_mem(j, want4[j]);
        b0.i_req = 1; b0.i_addr = 0;
        for (int j = 0; j < 3; j++) begin
            wait_ack(0, k);
            chk("t4_lat", k > 0, 1);
            chk("t4_rdata", b0.i_rdata, want4[j]);
            b0.i_addr += 4;
        end
        b0.i_req = 0;
        cyc();

        // Reset while the load counter sits at one
        apply_reset();
        set_mem(5, 32'h55);
        b0.d_req = 1; b0.d_we = 0; b0.d_addr = 32'h14;
        cyc();
        cyc();
        #1 rst_n0 = 0;
        #1;
        chk("t5_dack", b0.d_ack, 0);
        chk("t5_men", b0.m_en, 0);
        chk("t5_maddr", b0.m_addr, 0);
        chk("t5_mwe", b0.m_we, 0);
        chk("t5_drdata", b0.d_rdata, 0);
        chk("t5_irdata", b0.i_rdata, 0);
        chk("t5_busy", b0.busy, 0);
        model_reset();
        @(negedge clock);
        chk("t5_noack", b0.d_ack, 0);
        b0.i_req = 1; b0.i_addr = 32'h40;
        rst_n0 = 1;
        k = -1;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (b0.i_ack || b0.d_ack) begin
                k = c;
                break;
            end
        end
        chk("t5_lat", k, 3);
        chk("t5_first", b0.d_ack, 1);
        chk("t5_data", b0.d_rdata, 32'h55);
        b0.d_req = 0;
        wait_ack(0, k);
        chk("t5_fetch", k > 0, 1);
        b0.i_req = 0;
        cyc();

        // Random traffic against the model
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            cyc();
            if (b0.i_req) begin
                if (b0.i_ack) begin
                    if ($urandom_range(0, 3) != 0) b0.i_addr = $urandom();
                    else b0.i_req = 0;
                end else if ($urandom_range(0, 49) == 0) begin
                    b0.i_req = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                b0.i_req = 1;
                b0.i_addr = $urandom();
            end
            if (b0.d_req) begin
                if (b0.d_ack) begin
                    if ($urandom_range(0, 2) != 0) begin
                        b0.d_addr = $urandom();
                        b0.d_we = $urandom_range(0, 1);
                        b0.d_wdata = $urandom();
                    end else begin
                        b0.d_req = 0;
                    end
                end
            end else if ($urandom_range(0, 2) == 0) begin
                b0.d_req = 1;
                b0.d_addr = $urandom();
                b0.d_we = $urandom_range(0, 1);
                b0.d_wdata = $urandom();
            end
        end
        b0.i_req = 0; b0.d_req = 0;
        repeat (6) cyc();

        // MEM_LAT=1 instance: lone load
        rst_n1 = 1;
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h20;
        k = -1;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 1) chk("t6_men", b1.m_en, 1);
            if (b1.d_ack) begin
                k = c;
                break;
            end
        end
        chk("t6_lat", k, 2);
        chk("t6_rdata", b1.d_rdata, 32'hdd);
        chk("t6_maddr", b1.m_addr, 32'h20);
        b1.d_req = 0;
        cyc();
        chk("t6_idle", b1.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
